// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The master side drives operands and result-ready; the slave side is the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;

    modport master (
        output i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_diff, o_borrow
    );

    modport slave (
        input  i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_diff, o_borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: A - B computed LSB first over WIDTH cycles
// with one full-subtractor cell (two half_subt + OR) and a registered borrow.

module half_subt (
    input  logic a_i,
    input  logic b_i,
    output logic d_o,
    output logic bo_o
);
    assign d_o  = a_i ^ b_i;
    assign bo_o = ~a_i & b_i;
endmodule

// state | meaning
// IDLE  | o_ready high, waiting for an operand pair
// SHIFT | one difference bit produced per cycle, LSB first
// DONE  | o_valid high, result held until the consumer takes it
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    serial_subtractor_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             br_q,     br_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;

    logic             hs_d1, hs_bo1, d_bit, hs_bo2, br_next;
    logic [WIDTH-1:0] res_shifted;

    half_subt u_hs0 (
        .a_i  (a_sh_q[0]),
        .b_i  (b_sh_q[0]),
        .d_o  (hs_d1),
        .bo_o (hs_bo1)
    );

    half_subt u_hs1 (
        .a_i  (hs_d1),
        .b_i  (br_q),
        .d_o  (d_bit),
        .bo_o (hs_bo2)
    );

    assign br_next = hs_bo1 | hs_bo2;

    // New bit enters at the MSB so the register ends in natural bit order.
    always_comb begin
        res_shifted            = res_q >> 1;
        res_shifted[WIDTH-1]   = d_bit;
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    a_sh_d  = bus.i_a;
                    b_sh_d  = bus.i_b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_shifted;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    diff_d   = res_shifted;
                    borrow_d = br_next;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.o_ready  = (state_q == IDLE);
    assign bus.o_valid  = (state_q == DONE);
    assign bus.o_diff   = diff_q;
    assign bus.o_borrow = borrow_q;
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor that computes A − B over WIDTH clock cycles, one bit per cycle, LSB first. Each bit is processed by a full-subtractor cell built from two `half_subt` instances and an OR gate, with the borrow carried between cycles in a register. The block sits directly downstream of the operand source and upstream of the result consumer. It uses valid/ready handshakes on both sides and is intended for area-constrained paths where a WIDTH-bit parallel subtractor is not justified.

## Interface
- WIDTH, 8, operand and result width in bits; legal range is WIDTH ≥ 1.
- i_clk  input  1  the single clock; all state updates on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operand pair on i_a/i_b is valid.
- o_ready  output  1  block can accept operands; high only in IDLE.
- i_a  input  WIDTH  minuend, unsigned.
- i_b  input  WIDTH  subtrahend, unsigned.
- o_valid  output  1  result on o_diff/o_borrow is valid.
- i_ready  input  1  consumer accepts the result.
- o_diff  output  WIDTH  (A − B) mod 2^WIDTH.
- o_borrow  output  1  final borrow; equals 1 exactly when A < B.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- Reset (i_rst high at an edge):
  - state goes to IDLE; operand shift registers, borrow register and bit counter are cleared to 0.
  - o_diff = 0, o_borrow = 0, o_valid = 0, o_ready = 1 from the first cycle after the reset edge.
- IDLE:
  - o_ready = 1.
  - When i_valid && o_ready, capture i_a and i_b, clear borrow and counter, and go to SHIFT.
- SHIFT, each cycle:
  - The bit cell consumes a_sh[0], b_sh[0] and the borrow register.
  - Cell logic: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the MSB of the result register, which shifts right; a_sh and b_sh shift right; counter increments.
  - After the WIDTH-th SHIFT cycle, go to DONE. o_borrow takes the final br_next, and the result register holds the full difference in bit order.
- DONE:
  - o_valid = 1; o_diff and o_borrow are held stable.
  - When i_ready is high, go to IDLE and drop o_valid in the next cycle.
- i_valid outside IDLE is ignored; operands are not queued.
- o_diff and o_borrow change only on the SHIFT→DONE transition or on reset. Their values are undefined-free (zeros after reset) but meaningful only while o_valid is high.
- The counter width is clog2(WIDTH+1). There is no wrap-around, because the counter resets on every accept.

## Timing
- Accept happens in cycle k (i_valid && o_ready). SHIFT occupies cycles k+1 … k+WIDTH, and o_valid is first high in cycle k+WIDTH+1.
- Latency is WIDTH+1 cycles from the accept cycle to o_valid.
- o_ready is low from cycle k+1 until the cycle after the result handshake.
- Minimum initiation interval is WIDTH+2 cycles, with i_ready held high.
- Backpressure: o_valid stays high and the outputs hold indefinitely while i_ready is low. There is no combinational path from i_ready to o_ready.
- Reset mid-SHIFT or mid-DONE aborts the operation: the result is discarded, no o_valid pulse occurs, and o_ready is high the next cycle.
- If i_rst and i_valid are both high in the same cycle, reset wins and nothing is accepted.
- All outputs are driven directly from registers or from the state decode.

## Test plan
- WIDTH=8, A=0x5A, B=0x23, i_ready=1 → o_valid in cycle k+9; o_diff=0x37, o_borrow=0; o_ready returns high in cycle k+10.
- WIDTH=8, A=0x10, B=0x20 → o_diff=0xF0, o_borrow=1. Then A=0xFF, B=0x00 → 0xFF, borrow 0. Then A=0x00, B=0x00 → 0x00, borrow 0.
- Backpressure: A=0x80, B=0x01 with i_ready low for 5 cycles after o_valid rises → o_diff=0x7F held constant for all 5 cycles; handshake completes on the first i_ready-high cycle.
- i_valid held high with new operands during SHIFT → ignored; the first result is unchanged. The second operand pair is accepted only after returning to IDLE.
- i_rst pulsed in cycle k+4 of an 8-bit operation → no o_valid; o_diff=0, o_borrow=0, o_ready=1 the next cycle. A subsequent A=0x03, B=0x05 → o_diff=0xFE, o_borrow=1.
- WIDTH=1: exhaustive 4 input pairs → (0,1) gives diff=1, borrow=1; all other pairs give borrow=0. Latency is 2 cycles.
